// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, SR/Cause field positions, ExcCode values
// and the run/handler state encoding used by cp0_int_ctrl.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int SR_IM_MSB     = 15;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_IP_MSB  = 15;

  localparam logic [4:0] EXC_INT = 5'd0;

  // EXL doubles as the state bit, so HANDLER must encode as 1.
  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } cp0_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] v);
    return v & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cp0_sync.sv
// Multi-bit flop-chain synchroniser for level-sensitive asynchronous inputs.
// Output lags the input by STAGES clock edges.
module cp0_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt controller: SR/Cause/EPC/PRId, interrupt acceptance and ERET return.
// Optional build macro CP0_TIMER_EN adds Count/Compare with a sticky timer interrupt on IP[15].
module cp0_int_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL    = 32'h0000_7007,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  hw_int_i,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_addr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic        eret_i,
  output logic [31:0] cp0_rdata_o,
  output logic        int_req_o,
  output logic [31:0] epc_o,
  output logic        exl_o
);

  cp0_state_t  state_q, state_d;
  logic [5:0]  hw_sync;
  logic [5:0]  ip;
  logic [5:0]  im_q;
  logic        ie_q;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q;
  logic        exl;
  logic        pend;
  logic        int_req;
  logic        sr_we;
  logic        epc_we;

  cp0_sync #(
    .WIDTH  (6),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (hw_int_i),
    .q       (hw_sync)
  );

  assign sr_we  = cp0_we_i && (cp0_addr_i == CP0_SR);
  assign epc_we = cp0_we_i && (cp0_addr_i == CP0_EPC);

`ifdef CP0_TIMER_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_pend_q;
  logic        count_we;
  logic        compare_we;

  assign count_we   = cp0_we_i && (cp0_addr_i == CP0_COUNT);
  assign compare_we = cp0_we_i && (cp0_addr_i == CP0_COMPARE);

  // A Compare write re-arms the timer, so it beats a same-cycle match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q      <= '0;
      compare_q    <= '0;
      timer_pend_q <= 1'b0;
    end else begin
      count_q <= count_we ? cp0_wdata_i : count_q + 32'd1;
      if (compare_we) begin
        compare_q    <= cp0_wdata_i;
        timer_pend_q <= 1'b0;
      end else if (count_q == compare_q) begin
        timer_pend_q <= 1'b1;
      end
    end
  end

  assign ip = {hw_sync[5] | timer_pend_q, hw_sync[4:0]};
`else
  assign ip = hw_sync;
`endif

  assign exl  = (state_q == HANDLER);
  assign pend = (|(ip & im_q)) & ie_q & ~exl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  // ERET wins over everything; acceptance forces EXL over a same-cycle SR write.
  always_comb begin
    state_d = state_q;
    if (eret_i)       state_d = RUN;
    else if (int_req) state_d = HANDLER;
    else if (sr_we)   state_d = cp0_state_t'(cp0_wdata_i[SR_EXL_BIT]);
  end

  always_comb begin
    int_req = 1'b0;
    case (state_q)
      RUN:     int_req = pend & pc_valid_i & ~eret_i;
      HANDLER: int_req = 1'b0;
      default: int_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      im_q       <= '0;
      ie_q       <= 1'b0;
      exc_code_q <= EXC_INT;
      epc_q      <= '0;
    end else begin
      if (sr_we) begin
        im_q <= cp0_wdata_i[SR_IM_MSB:SR_IM_LSB];
        ie_q <= cp0_wdata_i[SR_IE_BIT];
      end
      if (int_req) begin
        epc_q      <= word_align(pc_i);
        exc_code_q <= EXC_INT;
      end else if (epc_we) begin
        epc_q <= word_align(cp0_wdata_i);
      end
    end
  end

  always_comb begin
    cp0_rdata_o = '0;
    case (cp0_addr_i)
      CP0_SR: begin
        cp0_rdata_o[SR_IM_MSB:SR_IM_LSB] = im_q;
        cp0_rdata_o[SR_EXL_BIT]          = exl;
        cp0_rdata_o[SR_IE_BIT]           = ie_q;
      end
      CP0_CAUSE: begin
        cp0_rdata_o[CAUSE_IP_MSB:CAUSE_IP_LSB]   = ip;
        cp0_rdata_o[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc_code_q;
      end
      CP0_EPC:     cp0_rdata_o = epc_q;
      CP0_PRID:    cp0_rdata_o = PRID_VAL;
`ifdef CP0_TIMER_EN
      CP0_COUNT:   cp0_rdata_o = count_q;
      CP0_COMPARE: cp0_rdata_o = compare_q;
`endif
      default:     cp0_rdata_o = '0;
    endcase
  end

  assign int_req_o = int_req;
  assign epc_o     = epc_q;
  assign exl_o     = exl;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Scoreboard bench for cp0_int_ctrl: a rule-level model predicts every cycle's outputs,
// a negedge monitor pops and compares. Timer scenarios run when CP0_TIMER_EN is defined.
module tb_cp0_int_ctrl;

  localparam int          SYNC = 2;
  localparam logic [31:0] PRID = 32'h0000_7007;

  logic        clk;
  logic        reset_n;
  logic [5:0]  hw_int;
  logic [31:0] pc;
  logic        pc_valid;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        eret;
  logic [31:0] cp0_rdata;
  logic        int_req;
  logic [31:0] epc;
  logic        exl;

  cp0_int_ctrl #(
    .PRID_VAL    (PRID),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hw_int_i    (hw_int),
    .pc_i        (pc),
    .pc_valid_i  (pc_valid),
    .cp0_we_i    (cp0_we),
    .cp0_addr_i  (cp0_addr),
    .cp0_wdata_i (cp0_wdata),
    .eret_i      (eret),
    .cp0_rdata_o (cp0_rdata),
    .int_req_o   (int_req),
    .epc_o       (epc),
    .exl_o       (exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] rdata;
    logic [31:0] epc;
    logic        exl;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cycle_no = 0;

  // Reference model state
  logic [5:0]  m_im;
  logic        m_ie;
  logic        m_exl;
  logic [31:0] m_epc;
  logic [5:0]  m_hist[$];
  logic [31:0] m_count;
  logic [31:0] m_compare;
  logic        m_tpend;

  function automatic void model_reset();
    m_im = '0; m_ie = 1'b0; m_exl = 1'b0; m_epc = '0;
    m_count = '0; m_compare = '0; m_tpend = 1'b0;
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(6'h00);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic [5:0] ip);
    case (a)
      5'd12:   return {16'h0, m_im, 8'h00, m_exl, m_ie};
      5'd13:   return {16'h0, ip, 10'h000};
      5'd14:   return m_epc;
      5'd15:   return PRID;
`ifdef CP0_TIMER_EN
      5'd9:    return m_count;
      5'd11:   return m_compare;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic cyc(input logic [5:0] h, input logic pv, input logic [31:0] p,
                     input logic we, input logic [4:0] a, input logic [31:0] wd,
                     input logic er);
    logic [5:0] ip;
    logic       pend, req, nexl, match;
    exp_t       e;
    hw_int = h; pc_valid = pv; pc = p; cp0_we = we; cp0_addr = a; cp0_wdata = wd; eret = er;
    ip = m_hist[0];
`ifdef CP0_TIMER_EN
    ip[5] = ip[5] | m_tpend;
`endif
    pend = (|(ip & m_im)) && m_ie && !m_exl;
    req  = pend && pv && !er;
    e.req = req; e.rdata = model_read(a, ip); e.epc = m_epc; e.exl = m_exl; e.cyc = cycle_no;
    sbq.push_back(e);
    if (er)                   nexl = 1'b0;
    else if (req)             nexl = 1'b1;
    else if (we && a == 5'd12) nexl = wd[1];
    else                      nexl = m_exl;
    if (we && a == 5'd12) begin m_im = wd[15:10]; m_ie = wd[0]; end
    if (req)                   m_epc = {p[31:2], 2'b00};
    else if (we && a == 5'd14) m_epc = {wd[31:2], 2'b00};
    match = (m_count == m_compare);
    if (we && a == 5'd11) begin m_compare = wd; m_tpend = 1'b0; end
    else if (match)       m_tpend = 1'b1;
    m_count = (we && a == 5'd9) ? wd : m_count + 32'd1;
    m_exl = nexl;
    m_hist.push_back(h);
    void'(m_hist.pop_front());
    @(posedge clk); #1;
    cycle_no++;
  endtask

  task automatic rd(input logic [5:0] h, input logic pv, input logic [31:0] p, input logic [4:0] a);
    cyc(h, pv, p, 1'b0, a, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [5:0] h, input logic pv, input logic [31:0] p,
                    input logic [4:0] a, input logic [31:0] wd);
    cyc(h, pv, p, 1'b1, a, wd, 1'b0);
  endtask

  task automatic do_reset();
    #1;
    reset_n = 1'b0;
    hw_int = '0; pc_valid = 1'b0; pc = '0; cp0_we = 1'b0; cp0_addr = '0; cp0_wdata = '0; eret = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want, input int c);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("int_req", {31'h0, int_req}, {31'h0, e.req}, e.cyc);
      chk("rdata",   cp0_rdata,        e.rdata,        e.cyc);
      chk("epc",     epc,              e.epc,          e.cyc);
      chk("exl",     {31'h0, exl},     {31'h0, e.exl}, e.cyc);
    end
  end

  initial begin
    logic [4:0]  addrs[7];
    logic [5:0]  line;
    logic [4:0]  a;
    logic [31:0] wd;
    addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
    reset_n = 1'b1;
    hw_int = '0; pc_valid = 1'b0; pc = '0; cp0_we = 1'b0; cp0_addr = '0; cp0_wdata = '0; eret = 1'b0;
    model_reset();
    @(posedge clk);
    do_reset();

    // Reset values of every register, mapped or not
    for (int i = 0; i < 7; i++) rd(6'h00, 1'b1, 32'h100, addrs[i]);

    // Basic interrupt: accepted two cycles after the raise, then EPC/SR/Cause
    wr(6'h00, 1'b1, 32'h0000_3000, 5'd12, 32'h0000_0401);
    rd(6'h01, 1'b1, 32'h0000_3010, 5'd13);
    rd(6'h01, 1'b1, 32'h0000_3010, 5'd13);
    rd(6'h01, 1'b1, 32'h0000_3010, 5'd13);
    rd(6'h01, 1'b1, 32'h0000_3014, 5'd14);
    rd(6'h01, 1'b1, 32'h0000_3018, 5'd12);
    rd(6'h01, 1'b1, 32'h0000_3018, 5'd13);

    // ERET with line still high, then EPC write colliding with re-acceptance
    cyc(6'h01, 1'b1, 32'h0000_301C, 1'b0, 5'd14, 32'h0, 1'b1);
    wr(6'h01, 1'b1, 32'h0000_3020, 5'd14, 32'h1234_5678);
    rd(6'h01, 1'b1, 32'h0000_3024, 5'd14);

    // Drop the line, return, then an idle EPC write with low bits set
    for (int i = 0; i < 3; i++) rd(6'h00, 1'b1, 32'h0000_3028, 5'd13);
    cyc(6'h00, 1'b1, 32'h0000_302C, 1'b0, 5'd13, 32'h0, 1'b1);
    wr(6'h00, 1'b1, 32'h0000_3030, 5'd14, 32'h0000_3003);
    rd(6'h00, 1'b1, 32'h0000_3034, 5'd14);

    // IE=0 masks a high line
    wr(6'h00, 1'b1, 32'h0000_3100, 5'd12, 32'h0000_0400);
    for (int i = 0; i < 8; i++) rd(6'h01, 1'b1, 32'h0000_3104 + 4*i, 5'd13);

    // Deferral: pending with bubbles, accepted on the first valid PC
    wr(6'h01, 1'b0, 32'h0000_3200, 5'd12, 32'h0000_0401);
    for (int i = 0; i < 3; i++) rd(6'h01, 1'b0, 32'hDEAD_0000 + i, 5'd12);
    rd(6'h01, 1'b1, 32'h0000_4000, 5'd14);
    rd(6'h01, 1'b1, 32'h0000_4004, 5'd14);

    // SR write clearing EXL leaves the handler; IE=0 keeps it from re-entering
    wr(6'h01, 1'b1, 32'h0000_4008, 5'd12, 32'h0000_0400);
    rd(6'h01, 1'b1, 32'h0000_400C, 5'd12);

    // SR write in the acceptance cycle: IM/IE from the write, EXL forced
    wr(6'h01, 1'b1, 32'h0000_4010, 5'd12, 32'h0000_0401);
    wr(6'h01, 1'b1, 32'h0000_4014, 5'd12, 32'h0000_0801);
    rd(6'h01, 1'b1, 32'h0000_4018, 5'd12);
    rd(6'h01, 1'b1, 32'h0000_4018, 5'd14);

    // Reset while in the handler
    do_reset();
    rd(6'h00, 1'b1, 32'h0000_5000, 5'd12);
    rd(6'h00, 1'b1, 32'h0000_5000, 5'd14);

`ifdef CP0_TIMER_EN
    // Timer: Compare=20, Count=0, IM[15]+IE; interrupt taken, then Compare write clears IP[15]
    wr(6'h00, 1'b0, 32'h0, 5'd11, 32'd20);
    wr(6'h00, 1'b0, 32'h0, 5'd9, 32'd0);
    wr(6'h00, 1'b0, 32'h0, 5'd12, 32'h0000_8001);
    for (int i = 0; i < 28; i++) rd(6'h00, 1'b1, 32'h0000_6000 + 4*i, (i % 2 == 0) ? 5'd9 : 5'd13);
    wr(6'h00, 1'b1, 32'h0000_6100, 5'd11, 32'd5000);
    for (int i = 0; i < 3; i++) rd(6'h00, 1'b1, 32'h0000_6104, 5'd13);
    cyc(6'h00, 1'b1, 32'h0000_6108, 1'b0, 5'd13, 32'h0, 1'b1);
    rd(6'h00, 1'b1, 32'h0000_610C, 5'd12);
`endif

    // Randomised traffic
    line = 6'h00;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) line = 6'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 6)];
      wd = $urandom;
      if (a == 5'd12 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
      if (a == 5'd12 && $urandom_range(0, 3) != 0) wd[1] = 1'b0;
      cyc(line, ($urandom_range(0, 3) != 0), $urandom,
          ($urandom_range(0, 7) == 0), a, wd,
          m_exl ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 39) == 0));
    end
    hw_int = '0; pc_valid = 1'b0; cp0_we = 1'b0; eret = 1'b0;

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", sbq.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_int_ctrl.md
Name: cp0_int_ctrl

Overview:
- Coprocessor-0 interrupt controller for the 5-stage MIPS pipeline.
- Synchronises external interrupt lines and holds SR, Cause, EPC and PRId.
- Decides when an interrupt is accepted and drives int_req_o, the flush/interrupt input consumed by the ID/EX pipeline register.
- Captures the victim PC into EPC, and restores on ERET via epc_o.

Parameters:
PRID_VAL, 32'h0000_7007, value returned on reads of PRId (reg 15)
SYNC_STAGES, 2, flip-flop depth of the hw_int_i synchroniser (legal: 2 or 3)

Ports:
clk  input  1  system clock, all state on posedge
reset_n  input  1  asynchronous active-low reset
hw_int_i  input  6  external interrupt lines, level-sensitive, asynchronous to clk
pc_i  input  32  PC of the instruction that will be the victim (re-executed after return)
pc_valid_i  input  1  pc_i belongs to a real instruction, not a bubble
cp0_we_i  input  1  mtc0 write strobe
cp0_addr_i  input  5  CP0 register index for mtc0/mfc0
cp0_wdata_i  input  32  mtc0 write data
eret_i  input  1  ERET executing this cycle
cp0_rdata_o  output  32  mfc0 read data, combinational on cp0_addr_i
int_req_o  output  1  interrupt accepted this cycle; flush the pipeline and redirect the PC to the handler
epc_o  output  32  current EPC, return target for ERET
exl_o  output  1  SR.EXL, handler mode

Behaviour:
- Reset (async, reset_n=0):
  - SR=0 (IM=0, EXL=0, IE=0); Cause=0; EPC=0.
  - All synchroniser flops = 0; state=RUN.
  - Outputs: int_req_o=0, epc_o=0, exl_o=0.
  - A reset mid-handler also returns the block to RUN.
- Register fields:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): IP[15:10] (read-only, from the synchroniser output), ExcCode[6:2] (0 = Int); other bits read 0.
  - EPC (14): 32 bits; bits [1:0] are forced to 0 on every write.
  - PRId (15): PRID_VAL, read-only.
  - Unmapped index: reads return 0, writes are ignored.
- Synchroniser: hw_int_i passes through SYNC_STAGES flops before reaching IP. Latency from a pin edge to IP visible is SYNC_STAGES cycles.
- Pending condition: pend = |(IP & IM) & IE & ~EXL.
- State machine, 2 states:
  - RUN (EXL=0):
    - int_req_o = pend & pc_valid_i, combinational.
    - On the clock edge where int_req_o=1: EPC<={pc_i[31:2],2'b00}, EXL<=1, ExcCode<=0, then go to HANDLER.
    - If pend=1 and pc_valid_i=0, acceptance is deferred, with no side effects, until a valid pc_i arrives.
  - HANDLER (EXL=1):
    - int_req_o=0.
    - eret_i=1 sets EXL<=0 and returns to RUN.
    - A still-pending interrupt may be accepted no earlier than the cycle after the return.
- Simultaneous events:
  - eret_i and pend in the same cycle: ERET has priority. No interrupt is accepted that cycle.
  - mtc0 to SR in the acceptance cycle: IM and IE take the written value; EXL is forced to 1.
  - mtc0 to EPC in the acceptance cycle: the write is dropped and the hardware capture wins.
  - mtc0 to SR with EXL=0 while in HANDLER: the state follows EXL and returns to RUN. EXL is the state bit.
  - A read in the same cycle as a write returns the old value; writes take effect at the edge.
- epc_o = EPC register, valid the cycle after capture.

Optional Feature:
Macro CP0_TIMER_EN.
- Defined:
  - Adds Count (reg 9) and Compare (reg 11), both 32 bits, both reset to 0.
  - Count increments every cycle, wrapping at 2^32-1 -> 0. An mtc0 write to Count overrides the increment that cycle.
  - When Count==Compare, a sticky timer-pending flop is set. It is ORed into IP[15].
  - Any mtc0 write to Compare clears the timer-pending flop.
- Undefined:
  - Regs 9 and 11 are unmapped (read 0).
  - IP[15] comes from hw_int_i[5] only.

Decomposition:
- Shared package cp0_pkg holds:
  - register index constants CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15, CP0_COUNT=9, CP0_COMPARE=11;
  - SR/Cause bit-position constants;
  - ExcCode Int=0;
  - state encoding RUN/HANDLER.
- One sub-module: cp0_sync, a parameterised multi-bit synchroniser, instantiated for hw_int_i.

Test Plan:
- Reset: release reset_n -> SR, Cause and EPC read 0; PRId reads 32'h0000_7007; int_req_o=0.
- Basic interrupt:
  - Stimulus: mtc0 SR=32'h0000_0401 (IM[10], IE=1); raise hw_int_i[0]; pc_i=32'h0000_3010, pc_valid_i=1.
  - Response: int_req_o=1 exactly 2 cycles after the raise, for 1 cycle. EPC=32'h0000_3010, exl_o=1, Cause.IP[10]=1, ExcCode=0.
- Masking/deferral:
  - IE=0 with a line high -> int_req_o never asserts.
  - IE=1, pending, pc_valid_i=0 for 3 cycles -> int_req_o stays 0. It asserts in the first cycle pc_valid_i=1, and EPC holds that cycle's pc_i.
- ERET collision: in HANDLER with the line still high, assert eret_i -> exl_o=0 next cycle, int_req_o=0 in the eret cycle, int_req_o=1 one cycle later.
- Write collision: mtc0 EPC=32'h1234_5678 in the acceptance cycle with pc_i=32'h0000_3020 -> EPC reads 32'h0000_3020. mtc0 EPC=32'h0000_3003 when idle -> EPC reads 32'h0000_3000.
- Timer (CP0_TIMER_EN defined):
  - Stimulus: Compare=20, Count=0, IM[15]=1, IE=1.
  - Response: int_req_o asserts once Count reaches 20 and the interrupt is taken. After the handler writes Compare, IP[15] clears.
